// File: rtl/aib_avmm_chnl_sequencer.sv
// Purpose : steer one host AVMM access at a time to the addressed channel slave.
// Latency : write 3 cycles, read 5 cycles with a zero-wait channel; the timeout bounds the worst case.
// Backpress: o_cfg_avmm_waitreq stays high until the single ACK cycle; channel waitreq stalls ACCESS.
//
// Ports:
//   i_cfg_avmm_*  host side: address, read/write strobes, write data, byte enables
//   o_cfg_avmm_*  host side: wait request, one-cycle read data valid, read data
//   o_chnl_*      one-hot channel read/write strobes, broadcast address/wdata/byte enables
//   i_chnl_*      per-channel wait request, read valid, and packed read-data lanes
//   o_addr_err    one-cycle pulse, aligned with ACK, when the channel index is out of range
//   o_timeout_err one-cycle pulse, aligned with ACK, when the access was aborted
module aib_avmm_chnl_sequencer #(
  parameter int NBR_CHNLS     = 24,
  parameter int ADDR_W        = 17,
  parameter int CHNL_ADDR_LSB = 11,
  parameter int TIMEOUT       = 255
) (
  input  logic                    i_cfg_avmm_clk,
  input  logic                    i_cfg_avmm_rst_n,
  input  logic [ADDR_W-1:0]       i_cfg_avmm_addr,
  input  logic                    i_cfg_avmm_read,
  input  logic                    i_cfg_avmm_write,
  input  logic [31:0]             i_cfg_avmm_wdata,
  input  logic [3:0]              i_cfg_avmm_byte_en,
  output logic                    o_cfg_avmm_waitreq,
  output logic                    o_cfg_avmm_rdatavld,
  output logic [31:0]             o_cfg_avmm_rdata,
  output logic [NBR_CHNLS-1:0]    o_chnl_read,
  output logic [NBR_CHNLS-1:0]    o_chnl_write,
  output logic [CHNL_ADDR_LSB-1:0] o_chnl_addr,
  output logic [31:0]             o_chnl_wdata,
  output logic [3:0]              o_chnl_byte_en,
  input  logic [NBR_CHNLS-1:0]    i_chnl_waitreq,
  input  logic [NBR_CHNLS-1:0]    i_chnl_rdatavld,
  input  logic [32*NBR_CHNLS-1:0] i_chnl_rdata,
  output logic                    o_addr_err,
  output logic                    o_timeout_err
);

  localparam int SEL_W = ADDR_W - CHNL_ADDR_LSB;
  // Counter value at which an unfinished access is abandoned.
  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDWAIT,
    ST_ACK,
    ST_RDVLD
  } state_t;

  state_t                   r_state;
  logic [15:0]              r_cnt;
  logic                     r_is_rd;
  logic [NBR_CHNLS-1:0]     r_sel_oh;
  logic                     r_waitreq;
  logic                     r_rdatavld;
  logic [31:0]              r_rdata;
  logic [NBR_CHNLS-1:0]     r_chnl_read;
  logic [NBR_CHNLS-1:0]     r_chnl_write;
  logic [CHNL_ADDR_LSB-1:0] r_chnl_addr;
  logic [31:0]              r_chnl_wdata;
  logic [3:0]               r_chnl_byte_en;
  logic                     r_addr_err;
  logic                     r_timeout_err;

  logic [SEL_W-1:0]         w_sel;
  logic                     w_sel_ok;
  logic [NBR_CHNLS-1:0]     w_sel_oh;
  logic                     w_cmd;
  logic                     w_accept;
  logic                     w_rvld;
  logic                     w_expire;
  logic [31:0]              w_lane;

  assign w_sel    = i_cfg_avmm_addr[ADDR_W-1:CHNL_ADDR_LSB];
  assign w_sel_ok = (32'(w_sel) < NBR_CHNLS);
  // An out-of-range index shifts the bit out entirely, leaving an empty mask.
  assign w_sel_oh = {{(NBR_CHNLS-1){1'b0}}, 1'b1} << w_sel;
  assign w_cmd    = i_cfg_avmm_read | i_cfg_avmm_write;

  // The selected channel is held as a one-hot mask so that accept and read
  // valid from every other channel are masked off.
  assign w_accept = |(r_sel_oh & ~i_chnl_waitreq);
  assign w_rvld   = |(r_sel_oh & i_chnl_rdatavld);
  assign w_expire = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_lane = '0;
    for (int k = 0; k < NBR_CHNLS; k++) begin
      if (r_sel_oh[k]) w_lane = w_lane | i_chnl_rdata[32*k +: 32];
    end
  end

  always_ff @(posedge i_cfg_avmm_clk) begin
    if (!i_cfg_avmm_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_is_rd        <= 1'b0;
      r_sel_oh       <= '0;
      r_waitreq      <= 1'b1;
      r_rdatavld     <= 1'b0;
      r_rdata        <= '0;
      r_chnl_read    <= '0;
      r_chnl_write   <= '0;
      r_chnl_addr    <= '0;
      r_chnl_wdata   <= '0;
      r_chnl_byte_en <= '0;
      r_addr_err     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_addr_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rdatavld    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_waitreq <= 1'b1;
          if (w_cmd) begin
            // Read takes priority when both strobes are raised together.
            r_is_rd        <= i_cfg_avmm_read;
            r_chnl_addr    <= i_cfg_avmm_addr[CHNL_ADDR_LSB-1:0];
            r_chnl_wdata   <= i_cfg_avmm_wdata;
            r_chnl_byte_en <= i_cfg_avmm_byte_en;
            if (w_sel_ok) begin
              r_sel_oh     <= w_sel_oh;
              r_chnl_read  <= i_cfg_avmm_read ? w_sel_oh : '0;
              r_chnl_write <= i_cfg_avmm_read ? '0 : w_sel_oh;
              r_cnt        <= '0;
              r_state      <= ST_ACCESS;
            end else begin
              r_sel_oh   <= '0;
              r_addr_err <= 1'b1;
              r_rdata    <= '0;
              r_waitreq  <= 1'b0;
              r_state    <= ST_ACK;
            end
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_accept) begin
            r_chnl_read  <= '0;
            r_chnl_write <= '0;
            if (r_is_rd) begin
              r_state <= ST_RDWAIT;
            end else begin
              r_waitreq <= 1'b0;
              r_state   <= ST_ACK;
            end
          end else if (w_expire) begin
            r_chnl_read   <= '0;
            r_chnl_write  <= '0;
            r_timeout_err <= 1'b1;
            r_rdata       <= 32'hFFFF_FFFF;
            r_waitreq     <= 1'b0;
            r_state       <= ST_ACK;
          end
        end
        ST_RDWAIT: begin
          r_cnt <= r_cnt + 16'd1;
          // Data arriving in the expiry cycle still completes normally.
          if (w_rvld) begin
            r_rdata   <= w_lane;
            r_waitreq <= 1'b0;
            r_state   <= ST_ACK;
          end else if (w_expire) begin
            r_timeout_err <= 1'b1;
            r_rdata       <= 32'hFFFF_FFFF;
            r_waitreq     <= 1'b0;
            r_state       <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_waitreq <= 1'b1;
          if (r_is_rd) begin
            r_rdatavld <= 1'b1;
            r_state    <= ST_RDVLD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RDVLD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cfg_avmm_waitreq  = r_waitreq;
  assign o_cfg_avmm_rdatavld = r_rdatavld;
  assign o_cfg_avmm_rdata    = r_rdata;
  assign o_chnl_read         = r_chnl_read;
  assign o_chnl_write        = r_chnl_write;
  assign o_chnl_addr         = r_chnl_addr;
  assign o_chnl_wdata        = r_chnl_wdata;
  assign o_chnl_byte_en      = r_chnl_byte_en;
  assign o_addr_err          = r_addr_err;
  assign o_timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_aib_avmm_chnl_sequencer.sv
// Directed bench for aib_avmm_chnl_sequencer with TIMEOUT=8: a table of
// host accesses with hand-computed cycle numbers, plus reset-state and
// reset-during-read sequences.
module tb_aib_avmm_chnl_sequencer;

  localparam int N = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [16:0]   h_addr;
  logic          h_rd, h_wr;
  logic [31:0]   h_wdata;
  logic [3:0]    h_be;
  logic          h_waitreq, h_rdatavld;
  logic [31:0]   h_rdata;
  logic [N-1:0]  c_read, c_write;
  logic [10:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic [N-1:0]  c_waitreq, c_rdatavld;
  logic [32*N-1:0] c_rdata;
  logic          addr_err, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aib_avmm_chnl_sequencer #(
    .NBR_CHNLS(N), .ADDR_W(17), .CHNL_ADDR_LSB(11), .TIMEOUT(8)
  ) dut (
    .i_cfg_avmm_clk     (clk),
    .i_cfg_avmm_rst_n   (rst_n),
    .i_cfg_avmm_addr    (h_addr),
    .i_cfg_avmm_read    (h_rd),
    .i_cfg_avmm_write   (h_wr),
    .i_cfg_avmm_wdata   (h_wdata),
    .i_cfg_avmm_byte_en (h_be),
    .o_cfg_avmm_waitreq (h_waitreq),
    .o_cfg_avmm_rdatavld(h_rdatavld),
    .o_cfg_avmm_rdata   (h_rdata),
    .o_chnl_read        (c_read),
    .o_chnl_write       (c_write),
    .o_chnl_addr        (c_addr),
    .o_chnl_wdata       (c_wdata),
    .o_chnl_byte_en     (c_be),
    .i_chnl_waitreq     (c_waitreq),
    .i_chnl_rdatavld    (c_rdatavld),
    .i_chnl_rdata       (c_rdata),
    .o_addr_err         (addr_err),
    .o_timeout_err      (timeout_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          wait_cyc;  // strobe cycles with waitreq high before accept (255 = never)
    int          rd_dly;    // cycles from accept to channel rdatavld
    logic [31:0] rdat;
    bit          spur;      // channel 0 also pulses rdatavld during the read
    logic [N-1:0] e_rd;
    logic [N-1:0] e_wr;
    int          e_sn;      // number of strobe cycles
    logic [10:0] e_caddr;
    int          e_ack;     // cycle with host waitreq low
    int          e_rv;      // cycle with host rdatavld, -1 none
    logic [31:0] e_rdat;
    int          e_aerr;
    int          e_terr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int id);
    int tgt, sn, acc, ack_cyc, ack_n, rv_cyc, rv_n, aerr_cyc, terr_cyc, multi;
    logic [N-1:0] seen_rd, seen_wr;
    logic [10:0] caddr;
    logic [31:0] cwdata, rv_dat;
    logic [3:0] cbe;
    bit ack_prev;
    tgt = int'(v.addr[16:11]);
    sn = 0; acc = -1; ack_cyc = -1; ack_n = 0; rv_cyc = -1; rv_n = 0;
    aerr_cyc = -1; terr_cyc = -1; multi = 0; ack_prev = 0;
    seen_rd = '0; seen_wr = '0; caddr = '0; cwdata = '0; cbe = '0; rv_dat = '0;
    for (int k = 0; k < N; k++)
      c_rdata[32*k +: 32] = (k == tgt) ? v.rdat :
                            (k == 0 && v.spur) ? 32'hFFFF_0000 : {16'hBAD0, 16'(k)};
    h_addr = v.addr; h_rd = v.rd; h_wr = v.wr; h_wdata = v.wdata; h_be = v.be;
    for (int c = 0; c < 40; c++) begin
      if (ack_prev) begin h_rd = 1'b0; h_wr = 1'b0; end
      c_waitreq = '1;
      c_rdatavld = '0;
      if ((c_read | c_write) != '0) begin
        sn++;
        seen_rd = seen_rd | c_read;
        seen_wr = seen_wr | c_write;
        caddr = c_addr; cwdata = c_wdata; cbe = c_be;
        if ($countones(c_read | c_write) > 1) multi++;
        if (tgt < N && (c_read[tgt] | c_write[tgt]) && sn > v.wait_cyc) begin
          c_waitreq[tgt] = 1'b0;
          if (acc < 0) acc = c;
        end
      end
      if (v.rd && acc >= 0 && c == acc + v.rd_dly && tgt < N) c_rdatavld[tgt] = 1'b1;
      if (v.spur && acc >= 0 && c == acc + 1) c_rdatavld[0] = 1'b1;
      ack_prev = 0;
      if (!h_waitreq) begin ack_n++; ack_prev = 1; if (ack_cyc < 0) ack_cyc = c; end
      if (h_rdatavld) begin rv_n++; if (rv_cyc < 0) begin rv_cyc = c; rv_dat = h_rdata; end end
      if (addr_err) aerr_cyc = c;
      if (timeout_err) terr_cyc = c;
      if (ack_cyc >= 0 && c >= ack_cyc + 3) break;
      tick();
    end
    h_rd = 1'b0; h_wr = 1'b0;
    c_waitreq = '1; c_rdatavld = '0;
    chk($sformatf("v%0d rd_strobe_mask", id), 32'(seen_rd), 32'(v.e_rd));
    chk($sformatf("v%0d wr_strobe_mask", id), 32'(seen_wr), 32'(v.e_wr));
    chk($sformatf("v%0d strobe_cycles", id), sn, v.e_sn);
    chk($sformatf("v%0d multi_hot", id), multi, 0);
    if (v.e_sn > 0) begin
      chk($sformatf("v%0d chnl_addr", id), 32'(caddr), 32'(v.e_caddr));
      chk($sformatf("v%0d chnl_wdata", id), cwdata, v.wdata);
      chk($sformatf("v%0d chnl_byte_en", id), 32'(cbe), 32'(v.be));
    end
    chk($sformatf("v%0d ack_cycle", id), ack_cyc, v.e_ack);
    chk($sformatf("v%0d ack_count", id), ack_n, 1);
    chk($sformatf("v%0d rdatavld_cycle", id), rv_cyc, v.e_rv);
    chk($sformatf("v%0d rdatavld_count", id), rv_n, (v.e_rv >= 0) ? 1 : 0);
    if (v.e_rv >= 0) chk($sformatf("v%0d rdata", id), rv_dat, v.e_rdat);
    chk($sformatf("v%0d addr_err_cycle", id), aerr_cyc, v.e_aerr);
    chk($sformatf("v%0d timeout_err_cycle", id), terr_cyc, v.e_terr);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " waitreq"}, 32'(h_waitreq), 32'd1);
    chk({tag, " rdatavld"}, 32'(h_rdatavld), 32'd0);
    chk({tag, " rdata"}, h_rdata, 32'd0);
    chk({tag, " chnl_read"}, 32'(c_read), 32'd0);
    chk({tag, " chnl_write"}, 32'(c_write), 32'd0);
    chk({tag, " chnl_addr"}, 32'(c_addr), 32'd0);
    chk({tag, " chnl_wdata"}, c_wdata, 32'd0);
    chk({tag, " chnl_byte_en"}, 32'(c_be), 32'd0);
    chk({tag, " addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int rv_n;
    //          rd  wr  addr      wdata         be    wt   dly rdat          sp e_rd     e_wr    sn caddr   ack rv  e_rdat        aerr terr
    vecs[0]  = '{0, 1, 17'h01804, 32'hA5A5_0001, 4'hF, 0,   0, 32'h0,        0, 24'h0,    24'h8,   1, 11'h004, 2, -1, 32'h0,         -1, -1};
    vecs[1]  = '{1, 0, 17'h0B810, 32'h0,         4'hF, 4,   3, 32'h1234_5678, 1, 24'h800000, 24'h0, 5, 11'h010, 9, 10, 32'h1234_5678, -1, -1};
    vecs[2]  = '{1, 0, 17'h0C000, 32'h0,         4'hF, 0,   1, 32'h0,        0, 24'h0,    24'h0,   0, 11'h000, 1,  2, 32'h0,          1, -1};
    vecs[3]  = '{1, 0, 17'h02820, 32'h0,         4'h3, 255, 1, 32'h5555_AAAA, 0, 24'h20,  24'h0,   8, 11'h020, 9, 10, 32'hFFFF_FFFF, -1,  9};
    vecs[4]  = '{1, 0, 17'h037FC, 32'h0,         4'hF, 1,   1, 32'hCAFE_BABE, 0, 24'h40,  24'h0,   2, 11'h7FC, 4,  5, 32'hCAFE_BABE, -1, -1};
    vecs[5]  = '{1, 1, 17'h00808, 32'h1111_2222, 4'h5, 0,   2, 32'h0BAD_F00D, 0, 24'h2,   24'h0,   1, 11'h008, 4,  5, 32'h0BAD_F00D, -1, -1};
    vecs[6]  = '{0, 1, 17'h0C004, 32'h7777_0000, 4'hF, 0,   0, 32'h0,        0, 24'h0,    24'h0,   0, 11'h000, 1, -1, 32'h0,          1, -1};
    vecs[7]  = '{0, 1, 17'h00000, 32'h0000_00AA, 4'h1, 255, 0, 32'h0,        0, 24'h0,    24'h1,   8, 11'h000, 9, -1, 32'h0,         -1,  9};
    vecs[8]  = '{1, 0, 17'h01100, 32'h0,         4'hF, 0,   7, 32'h2468_ACE0, 0, 24'h4,   24'h0,   1, 11'h100, 9, 10, 32'h2468_ACE0, -1, -1};
    vecs[9]  = '{1, 0, 17'h01100, 32'h0,         4'hF, 0,   8, 32'h2468_ACE0, 0, 24'h4,   24'h0,   1, 11'h100, 9, 10, 32'hFFFF_FFFF, -1,  9};
    vecs[10] = '{0, 1, 17'h04FFF, 32'hDEAD_BEEF, 4'hC, 7,   0, 32'h0,        0, 24'h0,    24'h200, 8, 11'h7FF, 9, -1, 32'h0,         -1, -1};

    rst_n = 1'b0; h_addr = '0; h_rd = 1'b0; h_wr = 1'b0; h_wdata = '0; h_be = '0;
    c_waitreq = '1; c_rdatavld = '0; c_rdata = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run(vecs[i], i);

    // Reset while a read to channel 4 sits in RDWAIT.
    h_addr = 17'h02000; h_rd = 1'b1; h_wr = 1'b0;
    tick();                                  // cycle 1: strobe
    chk("rst_seq strobe", 32'(c_read), 32'h10);
    c_waitreq[4] = 1'b0;
    tick();                                  // cycle 2: RDWAIT
    c_waitreq = '1;
    tick();                                  // cycle 3: RDWAIT
    rst_n = 1'b0; h_rd = 1'b0;
    c_rdatavld[4] = 1'b1; c_rdata[32*4 +: 32] = 32'h9999_9999;
    tick();
    chk_reset_outputs("mid_reset");
    rst_n = 1'b1;
    rv_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (h_rdatavld) rv_n++;
      if (!h_waitreq) rv_n++;
      tick();
    end
    c_rdatavld = '0;
    chk("mid_reset no_response", rv_n, 0);
    run(vecs[0], 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
